// File: rtl/j1x_cpu.sv
// rtl/j1x_cpu.sv - parametrised J1 stack CPU with I/O stall, sticky stack error flags
// Optional single-level maskable interrupt enabled by defining J1X_IRQ_EN.
module j1x_cpu #(
  parameter int          DW      = 16,
  parameter int          SP_BITS = 5,
  parameter int          PC_BITS = 13,
  parameter logic [12:0] IRQ_VEC = 13'h0001
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  output logic [PC_BITS-1:0] insn_addr,
  input  logic [15:0]        insn,
  output logic               io_rd,
  output logic               io_wr,
  output logic [DW-1:0]      io_addr,
  output logic [DW-1:0]      io_dout,
  input  logic [DW-1:0]      io_din,
  input  logic               io_ready,
`ifdef J1X_IRQ_EN
  input  logic               irq,
`endif
  output logic [1:0]         stk_err
);

  localparam int DEPTH = 1 << SP_BITS;
  localparam int SH    = $clog2(DW);

  logic [PC_BITS-1:0] pc, pc_n, pc_inc;
  logic [SP_BITS-1:0] dsp, dsp_n, rsp, rsp_n;
  logic [DW-1:0]      t, t_n, n, r, alu, depth_v, rs_wd;
  logic [1:0]         dd, rd;
  logic               ds_we, rs_we, stall, irq_take, d_wrap, r_wrap, is_alu;
  logic [3:0]         op;

  logic [DW-1:0] dstack [DEPTH];
  logic [DW-1:0] rstack [DEPTH];

  assign is_alu = (insn[15:13] == 3'b011);
  assign op     = insn[11:8];
  assign n      = dstack[dsp];
  assign r      = rstack[rsp];
  assign pc_inc = pc + 1'b1;

`ifdef J1X_IRQ_EN
  logic ie, ie_n, io_busy_q;
  // Never abort an I/O access already in progress.
  assign irq_take = !sys_rst_i && irq && ie && !io_busy_q;
`else
  logic unused_ie_bit;
  assign irq_take      = 1'b0;
  assign unused_ie_bit = insn[4];
`endif

  assign io_rd   = !sys_rst_i && !irq_take && is_alu && (op == 4'd12);
  assign io_wr   = !sys_rst_i && !irq_take && is_alu && insn[5];
  assign stall   = (io_rd || io_wr) && !io_ready;
  assign io_addr = t;
  assign io_dout = n;

  always_comb begin
    depth_v                = '0;
    depth_v[SP_BITS-1:0]   = dsp;
    depth_v[8 +: SP_BITS]  = rsp;
  end

  always_comb begin
    alu = t;
    case (op)
      4'd0:  alu = t;
      4'd1:  alu = n;
      4'd2:  alu = t + n;
      4'd3:  alu = t & n;
      4'd4:  alu = t | n;
      4'd5:  alu = t ^ n;
      4'd6:  alu = ~t;
      4'd7:  alu = {DW{n == t}};
      4'd8:  alu = {DW{$signed(n) < $signed(t)}};
      4'd9:  alu = n >> t[SH-1:0];
      4'd10: alu = t - 1'b1;
      4'd11: alu = r;
      4'd12: alu = io_din;
      4'd13: alu = n << t[SH-1:0];
      4'd14: alu = depth_v;
      default: alu = {DW{n < t}};
    endcase
  end

  always_comb begin
    t_n   = t;
    dd    = 2'b00;
    rd    = 2'b00;
    ds_we = 1'b0;
    rs_we = 1'b0;
    rs_wd = t;
    pc_n  = pc_inc;
`ifdef J1X_IRQ_EN
    ie_n  = ie;
`endif
    if (irq_take) begin
      // Push pc itself so a plain return re-runs the discarded instruction.
      rd    = 2'b01;
      rs_we = 1'b1;
      rs_wd = {{(DW-PC_BITS){1'b0}}, pc};
      pc_n  = IRQ_VEC[PC_BITS-1:0];
`ifdef J1X_IRQ_EN
      ie_n  = 1'b0;
`endif
    end else if (insn[15]) begin
      t_n   = {{(DW-15){1'b0}}, insn[14:0]};
      dd    = 2'b01;
      ds_we = 1'b1;
    end else begin
      case (insn[14:13])
        2'b00: pc_n = insn[PC_BITS-1:0];
        2'b01: begin
          t_n = n;
          dd  = 2'b11;
          if (t == '0) pc_n = insn[PC_BITS-1:0];
        end
        2'b10: begin
          rd    = 2'b01;
          rs_we = 1'b1;
          rs_wd = {{(DW-PC_BITS){1'b0}}, pc_inc};
          pc_n  = insn[PC_BITS-1:0];
        end
        default: begin
          t_n   = alu;
          dd    = insn[1:0];
          rd    = insn[3:2];
          ds_we = insn[7];
          rs_we = insn[6];
          if (insn[12]) pc_n = r[PC_BITS-1:0];
`ifdef J1X_IRQ_EN
          if (insn[4]) ie_n = t[0];
`endif
        end
      endcase
    end
  end

  assign dsp_n  = dsp + {{(SP_BITS-2){dd[1]}}, dd};
  assign rsp_n  = rsp + {{(SP_BITS-2){rd[1]}}, rd};
  assign d_wrap = ((dd == 2'b01) && (dsp_n < dsp)) || (dd[1] && (dsp_n > dsp));
  assign r_wrap = ((rd == 2'b01) && (rsp_n < rsp)) || (rd[1] && (rsp_n > rsp));

  assign insn_addr = sys_rst_i ? '0 : (stall ? pc : pc_n);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      pc      <= '0;
      dsp     <= '0;
      rsp     <= '0;
      t       <= '0;
      stk_err <= 2'b00;
    end else if (!stall) begin
      pc      <= pc_n;
      dsp     <= dsp_n;
      rsp     <= rsp_n;
      t       <= t_n;
      stk_err <= stk_err | {r_wrap, d_wrap};
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i && !stall) begin
      if (ds_we) dstack[dsp_n] <= t;
      if (rs_we) rstack[rsp_n] <= rs_wd;
    end
  end

`ifdef J1X_IRQ_EN
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ie        <= 1'b0;
      io_busy_q <= 1'b0;
    end else begin
      io_busy_q <= stall;
      if (!stall) ie <= ie_n;
    end
  end
`endif

endmodule

// File: doc/j1x_cpu.md
# j1x_cpu

Parametrised next-generation J1 stack CPU. Runs the 16-bit J1 instruction set over a configurable data width and stack depth. Adds three things: a ready/stall handshake on the I/O bus, sticky stack over/underflow flags, and an optional single-level maskable interrupt. It sits between a synchronous-read instruction RAM and the system I/O fabric, like the current core.

## Interface
- `DW`, 16, data/stack width; 16 or 32 only
- `SP_BITS`, 5, stack pointer width (3..8); each stack has 2**SP_BITS entries
- `PC_BITS`, 13, program counter width (1..13)
- `IRQ_VEC`, 13'h0001, interrupt entry address
- `sys_clk_i` in 1: clock
- `sys_rst_i` in 1: synchronous, active-high reset
- `insn_addr` out PC_BITS: next fetch address to synchronous instruction RAM
- `insn` in 16: instruction at the address presented on the previous cycle
- `io_rd` out 1: I/O read strobe
- `io_wr` out 1: I/O write strobe
- `io_addr` out DW: I/O address, equal to T
- `io_dout` out DW: write data, equal to N
- `io_din` in DW: read data
- `io_ready` in 1: completes the current I/O access
- `irq` in 1: level interrupt request; present only with J1X_IRQ_EN
- `stk_err` out 2: sticky flags {rstack error, dstack error}

One clock; reset is synchronous and active-high.

## Operation
- **Decode:**
  - `insn[15]=1`: literal. Push `insn[14:0]`, zero-extended to DW.
  - `insn[15:13]=000`: jump.
  - `001`: 0branch. Pop; branch if the popped T==0.
  - `010`: call. Push pc+1 to R.
  - `011`: ALU.
- **ALU fields:**
  - [12] R→PC
  - [11:8] op
  - [7] T→N (dstack write of old T)
  - [6] T→R
  - [5] I/O write
  - [4] IE←T[0], only with J1X_IRQ_EN, otherwise ignored
  - [3:2] R delta, sign-extended 2-bit
  - [1:0] D delta, sign-extended 2-bit
- **Ops 0..15:** T, N, T+N, T&N, T|N, T^N, ~T, N==T, N<T signed, N>>T, T-1, R, io_din, N<<T, depth, N<T unsigned.
  - Comparisons return all-ones or zero across DW.
  - Shift amount is `T[$clog2(DW)-1:0]`; shifts are logical.
  - Depth returns `rsp` in bits [15:8] and `dsp` in bits [7:0], zero-padded, with upper bits zero.
- **Arithmetic:** wraps modulo 2**DW.
- **Pointers:** wrap modulo 2**SP_BITS.
- **Overflow:**
  - A pointer update that wraps from 2**SP_BITS-1 to 0 (positive delta) sets that stack's `stk_err` bit.
  - A pointer update that wraps from 0 to 2**SP_BITS-1 (negative delta) also sets the bit.
  - The flags clear only on reset. The pointer still wraps.
- **I/O:**
  - `io_rd` = ALU op 12.
  - `io_wr` = ALU bit 5.
  - Both strobes are forced 0 during reset.
- **Stall:**
  - Condition: `(io_rd|io_wr) & !io_ready`.
  - While stalled, no register, stack or flag updates occur, and `insn_addr` holds at `pc`.
  - Strobes, `io_addr` and `io_dout` stay stable until the cycle `io_ready` is seen. The instruction completes in that cycle.
- **Next PC, in priority order:**
  1. Reset or stall: pc.
  2. Interrupt taken: IRQ_VEC.
  3. Jump, call, or taken 0branch: `insn[PC_BITS-1:0]`.
  4. ALU with bit 12 set: `R[PC_BITS-1:0]`.
  5. Otherwise pc+1.
- **Reset values:** pc=0, dsp=0, rsp=0, T=0, IE=0, `stk_err`=0, `io_rd`=`io_wr`=0, `insn_addr`=0. Stack RAM contents are not reset.

## Timing
- One instruction per cycle when not stalled.
- `insn_addr` is combinational from next-PC. `insn` is valid one cycle later.
- The first instruction executed after reset deasserts is at address 0.
- I/O access latency is 1 + the number of cycles with `io_ready` low. `io_ready` is sampled only in cycles where a strobe is high.
- Stack writes occur at the clock edge that commits the instruction. N and R reads are asynchronous from the current pointers.
- With reset held mid-stall, reset wins: the access is abandoned and the strobes drop in the next cycle.

## Configuration
- `J1X_IRQ_EN` defined:
  - The `irq` port exists and IE is writable via ALU bit 4.
  - The interrupt is taken when `irq & IE` at a non-stalled, non-reset instruction boundary.
  - Taking it discards the fetched instruction, pushes the current `pc` (not pc+1) to R with rsp+1, sets IE=0, and jumps to IRQ_VEC.
  - A normal R→PC return resumes at the discarded instruction.
  - Overflow on this push sets `stk_err[1]`.
- `J1X_IRQ_EN` undefined: there is no `irq` port, no IE register, and ALU bit 4 is ignored.

## Test plan
- **Arithmetic and branch, DW=32:** program `LIT 3`, `LIT 5`, `+`, `0branch`. Required: T=8 after the add, the 0branch falls through, dsp returns to 0.
- **Stall:** `io_wr` with `io_ready` low for 3 cycles. Required: strobe, address and data held 4 cycles; `insn_addr` constant; dsp updates only on the 4th cycle.
- **Read:** `io_rd` with `io_din`=32'hDEADBEEF and `io_ready`=1. Required: 1-cycle access, T=32'hDEADBEEF.
- **Overflow, SP_BITS=3:** 9 literal pushes. Required: `stk_err`=2'b01 after the 8th push. Then reset. Required: `stk_err`=0.
- **Interrupt:** IE set via ALU bit 4 with T=1, then `irq` asserted at pc=0x20. Required: `insn_addr`=IRQ_VEC, R top=0x20, IE=0; a return resumes at 0x20.
- **Reset mid-stall:** `sys_rst_i` asserted while stalled on `io_rd`. Required: `io_rd`=0 next cycle, and execution restarts at 0.
